// File: rtl/regfile_pkg.sv
// Shared types and constants for the 32x32 register file write path.
package regfile_pkg;

    localparam int REGFILE_AW    = 5;
    localparam int REGFILE_DW    = 32;
    localparam int REGFILE_NREGS = 32;

    localparam logic [REGFILE_AW-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic [REGFILE_AW-1:0] addr;
        logic [REGFILE_DW-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/regfile_wr_fifo.sv
// In-order write-request queue. Entries are exposed oldest-first (ent[0] is the head)
// together with a per-slot valid mask, so the owner can search them by age.
module regfile_wr_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  wr_req_t               push_req,
    input  logic                  pop,
    output logic                  full,
    output logic                  empty,
    output logic [CW-1:0]         count,
    output wr_req_t [DEPTH-1:0]   ent,
    output logic [DEPTH-1:0]      ent_vld
);

    wr_req_t [DEPTH-1:0] mem_q, mem_d;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_req;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Rotate storage into age order; pointers wrap naturally at PW bits.
    always_comb begin
        ent     = '0;
        ent_vld = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ent[i]     = mem_q[rd_ptr_q + PW'(i)];
            ent_vld[i] = CW'(i) < count_q;
        end
    end

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/regfile_write_port.sv
// Write-side front end of the register file: queues write-backs, drains one per cycle
// as one-hot enables, and flags pending writes to the read side.
// Optional macro REGFILE_WRITE_PORT_BYPASS_EN: per-address hit/forwarding instead of
// a conservative "anything pending" stall.
module regfile_write_port
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = REGFILE_AW,
    parameter int DW    = REGFILE_DW,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [AW-1:0]      wr_addr,
    input  logic [DW-1:0]      wr_data,
    input  logic               hold,
    output logic [2**AW-1:0]   we_onehot,
    output logic [DW-1:0]      we_data,
    output logic [CW-1:0]      pending,
    input  logic [AW-1:0]      rd_addr,
    output logic               rd_hit,
    output logic [DW-1:0]      rd_fwd_data
);

    wr_req_t [DEPTH-1:0] ent;
    logic [DEPTH-1:0]    ent_vld;
    logic                full, empty, push, pop;
    wr_req_t             push_req, head;

    logic [2**AW-1:0]    we_onehot_q, we_onehot_d;
    logic [DW-1:0]       we_data_q, we_data_d;

    // Writes to register 0 are acknowledged but never queued.
    assign wr_ready = !full;
    assign push     = wr_valid && wr_ready && (wr_addr != ZERO_REG);
    assign pop      = !hold && !empty;
    assign push_req = '{addr: wr_addr, data: wr_data};
    assign head     = ent[0];

    regfile_wr_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_req (push_req),
        .pop      (pop),
        .full     (full),
        .empty    (empty),
        .count    (pending),
        .ent      (ent),
        .ent_vld  (ent_vld)
    );

    always_comb begin
        we_onehot_d = '0;
        we_data_d   = we_data_q;
        if (pop) begin
            we_onehot_d[head.addr] = 1'b1;
            we_data_d              = head.data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            we_onehot_q <= '0;
            we_data_q   <= '0;
        end else begin
            we_onehot_q <= we_onehot_d;
            we_data_q   <= we_data_d;
        end
    end

    assign we_onehot = we_onehot_q;
    assign we_data   = we_data_q;

`ifdef REGFILE_WRITE_PORT_BYPASS_EN
    logic          rd_hit_c;
    logic [DW-1:0] rd_fwd_c;

    // Oldest source first so later (younger) matches override earlier ones.
    always_comb begin
        rd_hit_c = 1'b0;
        rd_fwd_c = '0;
        if (rd_addr != ZERO_REG) begin
            if (we_onehot_q[rd_addr]) begin
                rd_hit_c = 1'b1;
                rd_fwd_c = we_data_q;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (ent_vld[i] && ent[i].addr == rd_addr) begin
                    rd_hit_c = 1'b1;
                    rd_fwd_c = ent[i].data;
                end
            end
        end
    end

    assign rd_hit      = rd_hit_c;
    assign rd_fwd_data = rd_fwd_c;
`else
    logic bypass_unused;
    assign bypass_unused = ^{rd_addr, ent, ent_vld};
    assign rd_hit        = !empty || (|we_onehot_q);
    assign rd_fwd_data   = '0;
`endif

endmodule

// File: tb/tb_regfile_write_port.sv
// Directed self-checking bench for regfile_write_port; expectations follow the macro build.
module tb_regfile_write_port;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_valid;
    logic        wr_ready;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        hold;
    logic [31:0] we_onehot;
    logic [31:0] we_data;
    logic [2:0]  pending;
    logic [4:0]  rd_addr;
    logic        rd_hit;
    logic [31:0] rd_fwd_data;

    int vectors = 0;
    int miscompares = 0;
    int bit0_seen = 0;
    int multi_seen = 0;

`ifdef REGFILE_WRITE_PORT_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    regfile_write_port dut (
        .clk         (clk),
        .reset       (reset),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .hold        (hold),
        .we_onehot   (we_onehot),
        .we_data     (we_data),
        .pending     (pending),
        .rd_addr     (rd_addr),
        .rd_hit      (rd_hit),
        .rd_fwd_data (rd_fwd_data)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (we_onehot[0]) bit0_seen++;
        if ($countones(we_onehot) > 1) multi_seen++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [4:0] a, input logic [31:0] d);
        wr_valid = 1'b1; wr_addr = a; wr_data = d;
        step();
        wr_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; hold = 1'b0; rd_addr = 5'd3;
        step(); step();
        reset = 1'b0;
        vectors++; if (pending !== 3'd0) begin miscompares++; $display("FAIL reset_pending got %0d want 0", pending); end
        vectors++; if (we_onehot !== 32'h0) begin miscompares++; $display("FAIL reset_we got %h want 0", we_onehot); end
        vectors++; if (we_data !== 32'h0) begin miscompares++; $display("FAIL reset_data got %h want 0", we_data); end
        vectors++; if (wr_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b want 1", wr_ready); end
        vectors++; if (rd_hit !== 1'b0) begin miscompares++; $display("FAIL reset_hit got %b want 0", rd_hit); end
    endtask

    task automatic test_single();
        rd_addr = 5'd7;
        push_one(5'd7, 32'hDEADBEEF);
        vectors++; if (pending !== 3'd1) begin miscompares++; $display("FAIL single_pend1 got %0d want 1", pending); end
        vectors++; if (we_onehot !== 32'h0) begin miscompares++; $display("FAIL single_we_early got %h want 0", we_onehot); end
        step();
        vectors++; if (we_onehot !== 32'h80) begin miscompares++; $display("FAIL single_we got %h want 00000080", we_onehot); end
        vectors++; if (we_data !== 32'hDEADBEEF) begin miscompares++; $display("FAIL single_data got %h want deadbeef", we_data); end
        vectors++; if (pending !== 3'd0) begin miscompares++; $display("FAIL single_pend0 got %0d want 0", pending); end
        vectors++; if (rd_hit !== 1'b1) begin miscompares++; $display("FAIL single_inflight_hit got %b want 1", rd_hit); end
        vectors++; if (rd_fwd_data !== (BYP ? 32'hDEADBEEF : 32'h0)) begin miscompares++; $display("FAIL single_inflight_fwd got %h want %h", rd_fwd_data, BYP ? 32'hDEADBEEF : 32'h0); end
        step();
        vectors++; if (we_onehot !== 32'h0) begin miscompares++; $display("FAIL single_we_drop got %h want 0", we_onehot); end
        vectors++; if (we_data !== 32'hDEADBEEF) begin miscompares++; $display("FAIL single_data_hold got %h want deadbeef", we_data); end
        vectors++; if (rd_hit !== 1'b0) begin miscompares++; $display("FAIL single_idle_hit got %b want 0", rd_hit); end
    endtask

    task automatic test_fill_hold();
        logic [31:0] exp;
        hold = 1'b1;
        for (int i = 1; i <= 4; i++) push_one(5'(i), 32'h100 + i);
        vectors++; if (pending !== 3'd4) begin miscompares++; $display("FAIL fill_pending got %0d want 4", pending); end
        vectors++; if (wr_ready !== 1'b0) begin miscompares++; $display("FAIL fill_ready got %b want 0", wr_ready); end
        vectors++; if (we_onehot !== 32'h0) begin miscompares++; $display("FAIL fill_we got %h want 0", we_onehot); end
        push_one(5'd9, 32'h999);
        vectors++; if (pending !== 3'd4) begin miscompares++; $display("FAIL fill_reject got %0d want 4", pending); end
        hold = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step();
            exp = 32'h1 << i;
            vectors++; if (we_onehot !== exp) begin miscompares++; $display("FAIL drain_we%0d got %h want %h", i, we_onehot, exp); end
            vectors++; if (we_data !== 32'h100 + i) begin miscompares++; $display("FAIL drain_data%0d got %h want %h", i, we_data, 32'h100 + i); end
        end
        vectors++; if (wr_ready !== 1'b1) begin miscompares++; $display("FAIL drain_ready got %b want 1", wr_ready); end
        vectors++; if (pending !== 3'd0) begin miscompares++; $display("FAIL drain_pending got %0d want 0", pending); end
        step();
        vectors++; if (we_onehot !== 32'h0) begin miscompares++; $display("FAIL drain_idle got %h want 0", we_onehot); end
    endtask

    task automatic test_reg0();
        wr_valid = 1'b1; wr_addr = 5'd0; wr_data = 32'h12345678;
        #1;
        vectors++; if (wr_ready !== 1'b1) begin miscompares++; $display("FAIL reg0_ready got %b want 1", wr_ready); end
        step();
        wr_valid = 1'b0;
        vectors++; if (pending !== 3'd0) begin miscompares++; $display("FAIL reg0_pending got %0d want 0", pending); end
        step();
        vectors++; if (we_onehot !== 32'h0) begin miscompares++; $display("FAIL reg0_we got %h want 0", we_onehot); end
    endtask

    task automatic test_bypass();
        hold = 1'b1;
        push_one(5'd5, 32'h11);
        push_one(5'd5, 32'h22);
        rd_addr = 5'd5; #1;
        vectors++; if (rd_hit !== 1'b1) begin miscompares++; $display("FAIL byp_hit5 got %b want 1", rd_hit); end
        vectors++; if (rd_fwd_data !== (BYP ? 32'h22 : 32'h0)) begin miscompares++; $display("FAIL byp_fwd5 got %h want %h", rd_fwd_data, BYP ? 32'h22 : 32'h0); end
        rd_addr = 5'd6; #1;
        vectors++; if (rd_hit !== !BYP) begin miscompares++; $display("FAIL byp_hit6 got %b want %b", rd_hit, !BYP); end
        vectors++; if (rd_fwd_data !== 32'h0) begin miscompares++; $display("FAIL byp_fwd6 got %h want 0", rd_fwd_data); end
        rd_addr = 5'd0; #1;
        vectors++; if (rd_hit !== !BYP) begin miscompares++; $display("FAIL byp_hit0 got %b want %b", rd_hit, !BYP); end
        hold = 1'b0; rd_addr = 5'd5;
        step();
        vectors++; if (we_onehot !== 32'h20 || we_data !== 32'h11) begin miscompares++; $display("FAIL byp_drain1 got %h/%h want 00000020/00000011", we_onehot, we_data); end
        vectors++; if (rd_fwd_data !== (BYP ? 32'h22 : 32'h0)) begin miscompares++; $display("FAIL byp_young got %h want %h", rd_fwd_data, BYP ? 32'h22 : 32'h0); end
        step();
        vectors++; if (we_onehot !== 32'h20 || we_data !== 32'h22) begin miscompares++; $display("FAIL byp_drain2 got %h/%h want 00000020/00000022", we_onehot, we_data); end
        step();
        vectors++; if (pending !== 3'd0 || rd_hit !== 1'b0) begin miscompares++; $display("FAIL byp_empty got %0d/%b want 0/0", pending, rd_hit); end
    endtask

    task automatic test_reset_mid();
        hold = 1'b1;
        push_one(5'd10, 32'hA);
        push_one(5'd11, 32'hB);
        push_one(5'd12, 32'hC);
        vectors++; if (pending !== 3'd3) begin miscompares++; $display("FAIL rmid_pre got %0d want 3", pending); end
        reset = 1'b1;
        step();
        reset = 1'b0; hold = 1'b0;
        vectors++; if (pending !== 3'd0) begin miscompares++; $display("FAIL rmid_pending got %0d want 0", pending); end
        vectors++; if (we_onehot !== 32'h0) begin miscompares++; $display("FAIL rmid_we got %h want 0", we_onehot); end
        vectors++; if (wr_ready !== 1'b1) begin miscompares++; $display("FAIL rmid_ready got %b want 1", wr_ready); end
        for (int i = 0; i < 4; i++) begin
            step();
            vectors++; if (we_onehot !== 32'h0) begin miscompares++; $display("FAIL rmid_ghost%0d got %h want 0", i, we_onehot); end
        end
    endtask

    task automatic test_back_to_back();
        hold = 1'b1;
        push_one(5'd20, 32'h20);
        push_one(5'd21, 32'h21);
        hold = 1'b0;
        push_one(5'd22, 32'h22);
        vectors++; if (pending !== 3'd2) begin miscompares++; $display("FAIL b2b_pending got %0d want 2", pending); end
        vectors++; if (we_onehot !== 32'h0010_0000) begin miscompares++; $display("FAIL b2b_we0 got %h want 00100000", we_onehot); end
        step();
        vectors++; if (we_onehot !== 32'h0020_0000 || we_data !== 32'h21) begin miscompares++; $display("FAIL b2b_we1 got %h/%h want 00200000/00000021", we_onehot, we_data); end
        step();
        vectors++; if (we_onehot !== 32'h0040_0000 || we_data !== 32'h22) begin miscompares++; $display("FAIL b2b_we2 got %h/%h want 00400000/00000022", we_onehot, we_data); end
        vectors++; if (pending !== 3'd0) begin miscompares++; $display("FAIL b2b_end got %0d want 0", pending); end
        step();
    endtask

    task automatic test_invariants();
        vectors++; if (bit0_seen !== 0) begin miscompares++; $display("FAIL inv_bit0 got %0d want 0", bit0_seen); end
        vectors++; if (multi_seen !== 0) begin miscompares++; $display("FAIL inv_multihot got %0d want 0", multi_seen); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_hold();
        test_reg0();
        test_bypass();
        test_reset_mid();
        test_back_to_back();
        test_invariants();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
